cavlc_bitstream_feeder: RTL

//  Upstream stage of the CAVLC decoder. Packs MSB-first 32-bit RBSP words into a bit buffer.

---
 rtl/cavlc_bitstream_feeder_pkg.sv | 24 ++
 rtl/cavlc_bitstream_feeder_if.sv | 27 ++
 rtl/cavlc_bitstream_feeder_bit_shifter.sv | 27 ++
 rtl/cavlc_bitstream_feeder.sv | 91 +++++++++
 4 files changed

// File: rtl/cavlc_bitstream_feeder_pkg.sv
// Shared CAVLC front-end constants and helpers.
// The decoder top imports these so both sides agree on widths.
package cavlc_bitstream_feeder_pkg;

  localparam int IN_W  = 32;
  localparam int WIN_W = 16;
  localparam int BUF_W = 64;
  localparam int LEN_W = 5;
  localparam int CNT_W = 7;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIN_W);

  typedef enum logic [1:0] {
    CONS_NONE,
    CONS_DEC,
    CONS_ALIGN
  } cons_src_e;

  // The decoder never legally asks for more than one full window.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

endpackage

// File: rtl/cavlc_bitstream_feeder_if.sv
// Word-input stream plus decoder-side window/consume signals.
// The master is the RBSP source together with the decoder.
interface cavlc_bitstream_feeder_if;
  import cavlc_bitstream_feeder_pkg::*;

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [0:WIN_W-1] rbsp;
  logic             rbsp_valid;
  logic             dec_idle;
  logic [LEN_W-1:0] len_comb;
  logic             align;
  logic [2:0]       bit_pos;
  logic [CNT_W-1:0] bits_avail;

  modport master (
    output in_data, in_valid, dec_idle, len_comb, align,
    input  in_ready, rbsp, rbsp_valid, bit_pos, bits_avail
  );

  modport slave (
    input  in_data, in_valid, dec_idle, len_comb, align,
    output in_ready, rbsp, rbsp_valid, bit_pos, bits_avail
  );

endinterface

// File: rtl/cavlc_bitstream_feeder_bit_shifter.sv
// Combinational left shift of the bit buffer, then an optional word
// append at a variable offset. Index 0 of the buffer is the next stream bit.
module cavlc_bitstream_feeder_bit_shifter
  import cavlc_bitstream_feeder_pkg::*;
(
  input  logic [0:BUF_W-1] buf_in,
  input  logic [LEN_W-1:0] shift,
  input  logic [IN_W-1:0]  word,
  input  logic             append,
  input  logic [CNT_W-1:0] offset,
  output logic [0:BUF_W-1] buf_out
);

  logic [0:BUF_W-1] shifted;
  logic [0:BUF_W-1] placed;

  // Bits past the fill level are zero, so OR-ing the word in is enough.
  always_comb begin
    shifted = buf_in << shift;
    placed  = '0;
    if (append) begin
      placed = {word, {(BUF_W-IN_W){1'b0}}} >> offset;
    end
    buf_out = shifted | placed;
  end

endmodule

// File: rtl/cavlc_bitstream_feeder.sv
// Packs MSB-first RBSP words into a bit buffer and presents a registered
// 16-bit window to the CAVLC decoder, with byte alignment and slice flush.
module cavlc_bitstream_feeder
  import cavlc_bitstream_feeder_pkg::*;
(
  input logic                     clk,
  input logic                     rst_n,
  input logic                     ena,
  input logic                     flush,
  cavlc_bitstream_feeder_if.slave bus
);

  logic [0:BUF_W-1] bit_buf;
  logic [0:BUF_W-1] buf_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       pos;

  logic [LEN_W-1:0] len_ok;
  logic [LEN_W-1:0] cons;
  logic [2:0]       align_gap;
  cons_src_e        cons_src;
  logic             accept;
  logic [CNT_W-1:0] cnt_after_cons;
  logic [CNT_W-1:0] cnt_next;

  // Readiness only looks at the registered fill, so no path from len_comb.
  assign bus.in_ready   = ena && !flush && (cnt <= CNT_W'(BUF_W - IN_W));
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.rbsp       = bit_buf[0:WIN_W-1];
  assign bus.rbsp_valid = (cnt >= CNT_W'(WIN_W));
  assign bus.bit_pos    = pos;
  assign bus.bits_avail = cnt;

  // Decoder consumption wins; alignment only applies while the decoder idles.
  always_comb begin
    len_ok    = clamp_len(bus.len_comb);
    align_gap = 3'd0 - pos;
    cons_src  = CONS_NONE;
    cons      = '0;
    if (ena && !bus.dec_idle && bus.rbsp_valid) begin
      cons_src = CONS_DEC;
    end else if (ena && bus.align && bus.dec_idle && (cnt >= CNT_W'(align_gap))) begin
      cons_src = CONS_ALIGN;
    end
    case (cons_src)
      CONS_DEC:   cons = len_ok;
      CONS_ALIGN: cons = LEN_W'(align_gap);
      default:    cons = '0;
    endcase
    cnt_after_cons = cnt - CNT_W'(cons);
    cnt_next       = cnt_after_cons + (accept ? CNT_W'(IN_W) : CNT_W'(0));
  end

  cavlc_bitstream_feeder_bit_shifter u_shifter (
    .buf_in  (bit_buf),
    .shift   (cons),
    .word    (bus.in_data),
    .append  (accept),
    .offset  (cnt_after_cons),
    .buf_out (buf_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_buf <= '0;
      cnt     <= '0;
      pos     <= '0;
    end else if (ena) begin
      if (flush) begin
        bit_buf <= '0;
        cnt     <= '0;
        pos     <= '0;
      end else begin
        bit_buf <= buf_next;
        cnt     <= cnt_next;
        pos     <= pos + cons[2:0];
      end
    end
  end

  // Out-of-range lengths are clamped, but the decoder is still at fault.
  len_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    (ena && !bus.dec_idle) |-> (bus.len_comb <= MAX_LEN));

  decoder_not_starved: assert property (@(posedge clk) disable iff (!rst_n)
    (ena && !bus.dec_idle) |-> bus.rbsp_valid);

  fill_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= CNT_W'(BUF_W));

endmodule
